// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared ROB packet types and lane helpers
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

    localparam int XLEN      = `XLEN;
    localparam int TAG_W     = 6;
    localparam int CDB_IDX_W = 8;

    typedef struct packed {
        logic             completed;
        logic             precise_state_need;
        logic [XLEN-1:0]  target_pc;
        logic             halt;
        logic [TAG_W-1:0] dest_tag;
        logic [TAG_W-1:0] told_tag;
        logic [XLEN-1:0]  pc;
    } ROB_ENTRY_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [CDB_IDX_W-1:0] idx;
        logic                 precise_state_need;
        logic [XLEN-1:0]      target_pc;
    } ROB_CDB_PACKET;

    function automatic logic [1:0] lane_count(input logic [2:0] en);
        return 2'(en[0]) + 2'(en[1]) + 2'(en[2]);
    endfunction

endpackage

// File: rtl/reorder_buffer_ptr_ctrl.sv
// rtl/reorder_buffer_ptr_ctrl.sv - head/tail/count registers and occupancy flags
module rob_ptr_ctrl
    import sys_defs::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       dis_en,
    input  logic [2:0]       retire_en,
    input  logic             recover,
    output logic [IDX_W-1:0] head,
    output logic [IDX_W-1:0] tail,
    output logic [1:0]       space_avail,
    output logic             rob_empty,
    output logic             rob_full
);

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W:0]   free_slots;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (recover) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + IDX_W'(lane_count(retire_en));
            tail_d  = tail_q + IDX_W'(lane_count(dis_en));
            count_d = count_q + (IDX_W+1)'(lane_count(dis_en))
                              - (IDX_W+1)'(lane_count(retire_en));
        end
    end

    // Deliberately ignores same-cycle retirement so dispatch never races it.
    always_comb begin
        free_slots  = (IDX_W+1)'(DEPTH) - count_q;
        space_avail = (free_slots >= (IDX_W+1)'(3)) ? 2'd3 : free_slots[1:0];
    end

    assign head      = head_q;
    assign tail      = tail_q;
    assign rob_empty = (count_q == '0);
    assign rob_full  = (count_q == (IDX_W+1)'(DEPTH));

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 3-wide circular reorder buffer; lane 2 is always the oldest
module reorder_buffer
    import sys_defs::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [2:0]                 dis_en,
    input  ROB_ENTRY_PACKET [2:0]      dis_entry,
    output logic [2:0][IDX_W-1:0]      dis_rob_idx,
    output logic [1:0]                 space_avail,
    input  logic [2:0]                 cdb_valid,
    input  logic [2:0][IDX_W-1:0]      cdb_rob_idx,
    input  logic [2:0]                 cdb_precise_state_need,
    input  logic [2:0][XLEN-1:0]       cdb_target_pc,
    output ROB_ENTRY_PACKET [2:0]      rob_head_entry,
    input  logic [2:0]                 Retire_EN,
    input  logic                       BPRecoverEN,
    output logic                       rob_empty,
    output logic                       rob_full
);

    ROB_ENTRY_PACKET  entries_q [DEPTH];
    ROB_ENTRY_PACKET  entries_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [IDX_W-1:0] head, tail;
    ROB_CDB_PACKET [2:0] cdb_pkt;

    rob_ptr_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ptr (
        .clock       (clock),
        .reset       (reset),
        .dis_en      (dis_en),
        .retire_en   (Retire_EN),
        .recover     (BPRecoverEN),
        .head        (head),
        .tail        (tail),
        .space_avail (space_avail),
        .rob_empty   (rob_empty),
        .rob_full    (rob_full)
    );

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            cdb_pkt[k].valid              = cdb_valid[k];
            cdb_pkt[k].idx                = CDB_IDX_W'(cdb_rob_idx[k]);
            cdb_pkt[k].precise_state_need = cdb_precise_state_need[k];
            cdb_pkt[k].target_pc          = cdb_target_pc[k];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
        end
    end

    // Completion tests the registered valid, so a slot being dispatched this cycle ignores it.
    always_comb begin
        logic [IDX_W-1:0] slot;
        slot    = '0;
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) entries_d[i] = entries_q[i];
        if (BPRecoverEN) begin
            valid_d = '0;
        end else begin
            for (int k = 2; k >= 0; k--) begin
                if (dis_en[k]) begin
                    slot                               = tail + IDX_W'(2 - k);
                    entries_d[slot]                    = dis_entry[k];
                    entries_d[slot].completed          = 1'b0;
                    entries_d[slot].precise_state_need = 1'b0;
                    valid_d[slot]                      = 1'b1;
                end
            end
            // Ascending lane order lets the higher lane win on a shared index.
            for (int k = 0; k < 3; k++) begin
                slot = cdb_pkt[k].idx[IDX_W-1:0];
                if (cdb_pkt[k].valid && valid_q[slot]) begin
                    entries_d[slot].completed          = 1'b1;
                    entries_d[slot].precise_state_need = cdb_pkt[k].precise_state_need;
                    entries_d[slot].target_pc          = cdb_pkt[k].target_pc;
                end
            end
            for (int k = 2; k >= 0; k--) begin
                if (Retire_EN[k]) begin
                    slot          = head + IDX_W'(2 - k);
                    valid_d[slot] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic [IDX_W-1:0] slot;
        slot = '0;
        for (int k = 0; k < 3; k++) begin
            slot              = head + IDX_W'(2 - k);
            rob_head_entry[k] = valid_q[slot] ? entries_q[slot] : '0;
            dis_rob_idx[k]    = tail + IDX_W'(2 - k);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
    import sys_defs::*;

    localparam int DEPTH = 32;
    localparam int IDX_W = 5;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [2:0]            dis_en = '0;
    ROB_ENTRY_PACKET [2:0] dis_entry = '0;
    logic [2:0][IDX_W-1:0] dis_rob_idx;
    logic [1:0]            space_avail;
    logic [2:0]            cdb_valid = '0;
    logic [2:0][IDX_W-1:0] cdb_rob_idx = '0;
    logic [2:0]            cdb_psn = '0;
    logic [2:0][XLEN-1:0]  cdb_target_pc = '0;
    ROB_ENTRY_PACKET [2:0] rob_head_entry;
    logic [2:0]            Retire_EN = '0;
    logic                  BPRecoverEN = 1'b0;
    logic                  rob_empty, rob_full;

    int vecs = 0;
    int errs = 0;
    logic [2:0][IDX_W-1:0] exp_idx;

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .dis_en                 (dis_en),
        .dis_entry              (dis_entry),
        .dis_rob_idx            (dis_rob_idx),
        .space_avail            (space_avail),
        .cdb_valid              (cdb_valid),
        .cdb_rob_idx            (cdb_rob_idx),
        .cdb_precise_state_need (cdb_psn),
        .cdb_target_pc          (cdb_target_pc),
        .rob_head_entry         (rob_head_entry),
        .Retire_EN              (Retire_EN),
        .BPRecoverEN            (BPRecoverEN),
        .rob_empty              (rob_empty),
        .rob_full               (rob_full)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (!BPRecoverEN)
                assert (lane_count(dis_en) <= space_avail) else $error("dispatch beyond space_avail");
            for (int k = 0; k < 3; k++)
                if (Retire_EN[k])
                    assert (rob_head_entry[k].completed) else $error("retire of incomplete lane %0d", k);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        dis_en = '0; cdb_valid = '0; cdb_psn = '0; Retire_EN = '0; BPRecoverEN = 1'b0;
    endtask

    task automatic disp(input logic [2:0] en, input logic [31:0] base);
        dis_en = en;
        for (int k = 0; k < 3; k++) begin
            dis_entry[k]           = '0;
            dis_entry[k].completed = 1'b1;
            dis_entry[k].pc        = base + 32'(4 * (2 - k));
            dis_entry[k].dest_tag  = 6'(k + 1);
        end
    endtask

    task automatic cpl(input int lane, input int idx, input logic psn, input logic [31:0] tpc);
        cdb_valid[lane]     = 1'b1;
        cdb_rob_idx[lane]   = IDX_W'(idx);
        cdb_psn[lane]       = psn;
        cdb_target_pc[lane] = tpc;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); tick(); tick(); reset = 1'b0; tick();
        exp_idx = {5'd0, 5'd1, 5'd2};
        vecs++; if (rob_empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b want 1", rob_empty); end
        vecs++; if (rob_full !== 1'b0) begin errs++; $display("FAIL reset_full got %b want 0", rob_full); end
        vecs++; if (space_avail !== 2'd3) begin errs++; $display("FAIL reset_space got %0d want 3", space_avail); end
        vecs++; if (rob_head_entry !== '0) begin errs++; $display("FAIL reset_head got %h want 0", rob_head_entry); end
        vecs++; if (dis_rob_idx !== exp_idx) begin errs++; $display("FAIL reset_idx got %h want %h", dis_rob_idx, exp_idx); end
    endtask

    task automatic test_complete_order();
        disp(3'b111, 32'h100); tick(); idle();
        exp_idx = {5'd3, 5'd4, 5'd5};
        vecs++; if (dis_rob_idx !== exp_idx) begin errs++; $display("FAIL co_idx got %h want %h", dis_rob_idx, exp_idx); end
        vecs++; if (rob_head_entry[2].pc !== 32'h100) begin errs++; $display("FAIL co_pc2 got %h want 100", rob_head_entry[2].pc); end
        vecs++; if (rob_head_entry[0].pc !== 32'h108) begin errs++; $display("FAIL co_pc0 got %h want 108", rob_head_entry[0].pc); end
        vecs++; if (rob_head_entry[2].completed !== 1'b0) begin errs++; $display("FAIL co_disp_cpl got %b want 0", rob_head_entry[2].completed); end
        cpl(2, 1, 1'b0, 32'h0); tick(); idle();
        vecs++; if (rob_head_entry[2].completed !== 1'b0) begin errs++; $display("FAIL co_l2_early got %b want 0", rob_head_entry[2].completed); end
        vecs++; if (rob_head_entry[1].completed !== 1'b1) begin errs++; $display("FAIL co_l1 got %b want 1", rob_head_entry[1].completed); end
        cpl(2, 0, 1'b0, 32'h0); tick(); idle();
        vecs++; if (rob_head_entry[2].completed !== 1'b1) begin errs++; $display("FAIL co_l2 got %b want 1", rob_head_entry[2].completed); end
        cpl(2, 2, 1'b0, 32'h0); tick(); idle();
        vecs++; if (rob_head_entry[0].completed !== 1'b1) begin errs++; $display("FAIL co_l0 got %b want 1", rob_head_entry[0].completed); end
        Retire_EN = 3'b110; tick(); idle();
        vecs++; if (dut.u_ptr.head_q !== 5'd2) begin errs++; $display("FAIL co_head2 got %0d want 2", dut.u_ptr.head_q); end
        vecs++; if (rob_head_entry[2].pc !== 32'h108) begin errs++; $display("FAIL co_shift got %h want 108", rob_head_entry[2].pc); end
        vecs++; if (rob_head_entry[1] !== '0) begin errs++; $display("FAIL co_past_tail got %h want 0", rob_head_entry[1]); end
        Retire_EN = 3'b100; tick(); idle();
        vecs++; if (dut.u_ptr.head_q !== 5'd3) begin errs++; $display("FAIL co_head3 got %0d want 3", dut.u_ptr.head_q); end
        vecs++; if (rob_empty !== 1'b1) begin errs++; $display("FAIL co_empty got %b want 1", rob_empty); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 10; i++) begin
            disp(3'b111, 32'h1000 + 32'(12 * i)); tick();
        end
        idle();
        vecs++; if (space_avail !== 2'd2) begin errs++; $display("FAIL fu_space30 got %0d want 2", space_avail); end
        vecs++; if (rob_full !== 1'b0) begin errs++; $display("FAIL fu_full30 got %b want 0", rob_full); end
        disp(3'b110, 32'h1100); tick(); idle();
        vecs++; if (rob_full !== 1'b1) begin errs++; $display("FAIL fu_full got %b want 1", rob_full); end
        vecs++; if (space_avail !== 2'd0) begin errs++; $display("FAIL fu_space0 got %0d want 0", space_avail); end
        vecs++; if (dis_rob_idx[2] !== 5'd3) begin errs++; $display("FAIL fu_tailwrap got %0d want 3", dis_rob_idx[2]); end
        cpl(2, 3, 1'b0, 32'h0); cpl(1, 4, 1'b0, 32'h0); tick(); idle();
        Retire_EN = 3'b100; tick(); idle();
        vecs++; if (space_avail !== 2'd1) begin errs++; $display("FAIL fu_space31 got %0d want 1", space_avail); end
        Retire_EN = 3'b100; disp(3'b100, 32'h1200); tick(); idle();
        vecs++; if (space_avail !== 2'd1) begin errs++; $display("FAIL fu_swap_space got %0d want 1", space_avail); end
        vecs++; if (dut.u_ptr.head_q !== 5'd5) begin errs++; $display("FAIL fu_swap_head got %0d want 5", dut.u_ptr.head_q); end
        vecs++; if (dis_rob_idx[2] !== 5'd4) begin errs++; $display("FAIL fu_swap_tail got %0d want 4", dis_rob_idx[2]); end
        disp(3'b100, 32'h1300); tick(); idle();
        vecs++; if (rob_full !== 1'b1) begin errs++; $display("FAIL fu_refull got %b want 1", rob_full); end
        vecs++; if (rob_head_entry[2].pc !== 32'h1008) begin errs++; $display("FAIL fu_headpc got %h want 1008", rob_head_entry[2].pc); end
    endtask

    task automatic test_recover();
        BPRecoverEN = 1'b1; disp(3'b111, 32'h1400); cpl(2, 5, 1'b1, 32'h0); tick(); idle();
        exp_idx = {5'd0, 5'd1, 5'd2};
        vecs++; if (rob_empty !== 1'b1) begin errs++; $display("FAIL rc_empty got %b want 1", rob_empty); end
        vecs++; if (dut.u_ptr.head_q !== 5'd0) begin errs++; $display("FAIL rc_head got %0d want 0", dut.u_ptr.head_q); end
        vecs++; if (dis_rob_idx !== exp_idx) begin errs++; $display("FAIL rc_idx got %h want %h", dis_rob_idx, exp_idx); end
        vecs++; if (rob_head_entry !== '0) begin errs++; $display("FAIL rc_head_entry got %h want 0", rob_head_entry); end
        vecs++; if (space_avail !== 2'd3) begin errs++; $display("FAIL rc_space got %0d want 3", space_avail); end
        disp(3'b100, 32'h2000); tick(); idle();
        vecs++; if (rob_head_entry[2].pc !== 32'h2000) begin errs++; $display("FAIL rc_first_pc got %h want 2000", rob_head_entry[2].pc); end
        vecs++; if (dis_rob_idx[2] !== 5'd1) begin errs++; $display("FAIL rc_first_idx got %0d want 1", dis_rob_idx[2]); end
        BPRecoverEN = 1'b1; tick(); idle();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            disp(3'b111, 32'h3000 + 32'(12 * i)); tick();
        end
        idle();
        for (int i = 0; i < 10; i++) begin
            cpl(2, 3 * i, 1'b0, 32'h0); cpl(1, 3 * i + 1, 1'b0, 32'h0); cpl(0, 3 * i + 2, 1'b0, 32'h0);
            tick(); idle();
            Retire_EN = 3'b111; tick(); idle();
        end
        vecs++; if (dut.u_ptr.head_q !== 5'd30) begin errs++; $display("FAIL wr_head30 got %0d want 30", dut.u_ptr.head_q); end
        disp(3'b111, 32'h4000); tick(); idle();
        exp_idx = {5'd1, 5'd2, 5'd3};
        vecs++; if (dis_rob_idx !== exp_idx) begin errs++; $display("FAIL wr_idx got %h want %h", dis_rob_idx, exp_idx); end
        cpl(2, 30, 1'b0, 32'h0); cpl(1, 31, 1'b0, 32'h0); cpl(0, 0, 1'b0, 32'h0); tick(); idle();
        vecs++; if (rob_head_entry[2].pc !== 32'h4000) begin errs++; $display("FAIL wr_l2 got %h want 4000", rob_head_entry[2].pc); end
        vecs++; if (rob_head_entry[1].pc !== 32'h4004) begin errs++; $display("FAIL wr_l1 got %h want 4004", rob_head_entry[1].pc); end
        vecs++; if (rob_head_entry[0].pc !== 32'h4008) begin errs++; $display("FAIL wr_l0 got %h want 4008", rob_head_entry[0].pc); end
        vecs++; if (rob_head_entry[0].completed !== 1'b1) begin errs++; $display("FAIL wr_l0_cpl got %b want 1", rob_head_entry[0].completed); end
        Retire_EN = 3'b111; tick(); idle();
        vecs++; if (dut.u_ptr.head_q !== 5'd1) begin errs++; $display("FAIL wr_head1 got %0d want 1", dut.u_ptr.head_q); end
        vecs++; if (rob_empty !== 1'b1) begin errs++; $display("FAIL wr_empty got %b want 1", rob_empty); end
    endtask

    task automatic test_precise();
        disp(3'b100, 32'h5000); tick(); idle();
        cpl(2, 1, 1'b1, 32'h8000_0000); cpl(0, 1, 1'b0, 32'h0000_1234); tick(); idle();
        vecs++; if (rob_head_entry[2].precise_state_need !== 1'b1) begin errs++; $display("FAIL pr_psn got %b want 1", rob_head_entry[2].precise_state_need); end
        vecs++; if (rob_head_entry[2].target_pc !== 32'h8000_0000) begin errs++; $display("FAIL pr_tpc got %h want 80000000", rob_head_entry[2].target_pc); end
        vecs++; if (rob_head_entry[2].completed !== 1'b1) begin errs++; $display("FAIL pr_cpl got %b want 1", rob_head_entry[2].completed); end
        disp(3'b100, 32'h5004); cpl(1, 2, 1'b1, 32'hdead_beef); tick(); idle();
        vecs++; if (rob_head_entry[1].completed !== 1'b0) begin errs++; $display("FAIL pr_invalid_cpl got %b want 0", rob_head_entry[1].completed); end
        vecs++; if (rob_head_entry[1].pc !== 32'h5004) begin errs++; $display("FAIL pr_l1_pc got %h want 5004", rob_head_entry[1].pc); end
    endtask

    task automatic test_async_reset();
        disp(3'b111, 32'h6000); tick(); idle();
        #2 reset = 1'b1;
        #1;
        vecs++; if (rob_empty !== 1'b1) begin errs++; $display("FAIL ar_empty got %b want 1", rob_empty); end
        vecs++; if (rob_head_entry !== '0) begin errs++; $display("FAIL ar_head got %h want 0", rob_head_entry); end
        tick(); reset = 1'b0; tick();
        vecs++; if (dis_rob_idx[2] !== 5'd0) begin errs++; $display("FAIL ar_tail got %0d want 0", dis_rob_idx[2]); end
    endtask

    initial begin
        test_reset();
        test_complete_order();
        test_full();
        test_recover();
        test_wrap();
        test_precise();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
